out_byte_uart_tx: RTL and testbench
===================================

Name: out_byte_uart_tx

Overview:
Downstream consumer of the CPU system's memory-mapped byte port (out_byte / out_byte_en pulses from stores to 0x1000_0000).
- Buffers each strobed byte in a small FIFO.
- Serialises bytes onto a UART TX line, 8N1, LSB first, at a fixed divider.
- Lets firmware print text to a host terminal alongside the seven-segment display, without CPU stalls.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Legal range 2..65535.
FIFO_AW, 4, FIFO address width. Depth = 2**FIFO_AW = 16 entries.

Ports:
clk  input  1  system clock; all state changes on rising edge
resetn  input  1  asynchronous active-low reset
in_byte  input  8  byte to transmit; sampled only when in_byte_en=1
in_byte_en  input  1  single-cycle write strobe; one byte per high cycle
overflow_clr  input  1  synchronous clear of the sticky overflow flag
uart_tx  output  1  serial line, registered, idle high
tx_busy  output  1  high while a frame is being shifted out (state != IDLE)
fifo_level  output  FIFO_AW+1  number of bytes buffered, 0..16; excludes the byte in the shifter
fifo_full  output  1  fifo_level == 2**FIFO_AW
overflow  output  1  sticky: a strobe arrived while fifo_full

Behaviour:
- Reset (resetn=0, asynchronous, effective at any time including mid-frame):
  - uart_tx=1, tx_busy=0, fifo_level=0, fifo_full=0, overflow=0.
  - FSM goes to IDLE; bit and baud counters are 0; FIFO pointers are 0. Buffered data is discarded.
  - Leaving reset, the line stays high until a new byte is pushed.
- FIFO:
  - Circular buffer with wr_ptr and rd_ptr, each FIFO_AW+1 bits, wrapping modulo 2*depth. Level = wr_ptr - rd_ptr.
  - Push: on an edge with in_byte_en=1 and fifo_full=0 (value before the edge), in_byte is written at wr_ptr.
  - Dropped push: if in_byte_en=1 while fifo_full=1, the byte is discarded and overflow is set.
  - Pop: happens only when the FSM loads the shifter.
  - Push and pop on the same edge: both take effect and the level is unchanged. A pop does not free space for a push on the same edge when full; the full test uses the pre-edge level.
  - Empty FIFO plus push on the same edge: no pop that edge. Data is never bypassed.
- overflow_clr: clears overflow on the next edge. If a set and a clear occur on the same edge, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: uart_tx=1. If fifo_level != 0, pop the head into an 8-bit shifter, clear baud_cnt, and go to START. uart_tx goes 0 on that same edge.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0. uart_tx = shifter[0].
  - DATA: each bit is held CLKS_PER_BIT cycles. Shift right after each bit. After bit 7 completes, go to STOP with uart_tx=1.
  - STOP: hold 1 for CLKS_PER_BIT cycles. On completion:
    - if fifo_level != 0, pop and go directly to START (back-to-back frames, no extra idle time);
    - otherwise go to IDLE.
- baud_cnt counts 0..CLKS_PER_BIT-1. A bit ends on the edge where baud_cnt == CLKS_PER_BIT-1; baud_cnt then returns to 0.
- Timing:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Latency from the edge that writes an empty FIFO to the falling start edge of uart_tx is exactly 1 clock.
- Throughput: one byte per 10*CLKS_PER_BIT cycles. Capacity is 16 buffered bytes plus 1 in the shifter.
- tx_busy is derived from the registered state only; it has no combinational input path.

Test Plan:
1. CLKS_PER_BIT=4; push 0xA5 once.
   - uart_tx falls 1 edge after the push.
   - Line reads 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
   - tx_busy is high for exactly 40 cycles; fifo_level is 1 for one cycle, then 0.
2. CLKS_PER_BIT=4; push 0x48, 0x69, 0x0A on 3 consecutive cycles.
   - Three contiguous 40-cycle frames, with no idle gap between stop and start bits.
   - fifo_level sequence: 1,1,2,1 (during frame 1), then 0.
3. CLKS_PER_BIT=4; push 18 bytes 0x00..0x11 on consecutive cycles.
   - Byte 0x11 is dropped; overflow=1; fifo_full=1 after the 17th push.
   - Serial output is 0x00..0x10 in order, 17 frames.
4. With overflow=1, pulse overflow_clr.
   - overflow=0 next cycle.
   - Repeat with overflow_clr on the same edge as a dropped push: overflow stays 1.
5. Assert resetn=0 mid-DATA of a frame with 5 bytes queued.
   - uart_tx=1 immediately, with no clock needed; fifo_level=0; tx_busy=0.
   - After release, no frame is emitted until a new push.
6. CLKS_PER_BIT=2 (minimum); push 0xFF then 0x00.
   - Correct frames of 20 cycles each.
   - The bit boundaries confirm there is no off-by-one in baud_cnt.

Source files
------------

// File: rtl/out_byte_uart_tx.sv
// Byte-strobe to UART bridge: a small FIFO buffers strobed bytes, which are then
// shifted out as 8N1 frames, LSB first, at a fixed clocks-per-bit divider.
module out_byte_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         in_byte,
    input  logic               in_byte_en,
    input  logic               overflow_clr,
    output logic               uart_tx,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               fifo_full,
    output logic               overflow
);

    localparam int                DEPTH_C      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  FULL_LEVEL_C = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]  PTR_ONE_C    = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [15:0]       BIT_LAST_C   = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE_S  = 2'd0,
        START_S = 2'd1,
        DATA_S  = 2'd2,
        STOP_S  = 2'd3
    } state_t;

    logic [7:0]       mem_r [DEPTH_C];
    logic [FIFO_AW:0] wr_ptr_r;
    logic [FIFO_AW:0] rd_ptr_r;
    logic             overflow_r;
    state_t           state_r;
    state_t           state_n_s;
    logic [15:0]      baud_cnt_r;
    logic [15:0]      baud_cnt_n_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_n_s;
    logic [7:0]       shifter_r;
    logic [7:0]       shifter_n_s;
    logic             tx_r;
    logic             tx_n_s;
    logic             pop_s;

    // Full/push decisions use the pre-edge level, so a same-edge pop never frees a slot.
    logic [FIFO_AW:0] level_s;
    logic             full_s;
    logic             push_s;
    logic             ovf_set_s;
    logic             bit_end_s;
    assign level_s   = wr_ptr_r - rd_ptr_r;
    assign full_s    = (level_s == FULL_LEVEL_C);
    assign push_s    = in_byte_en & ~full_s;
    assign ovf_set_s = in_byte_en & full_s;
    assign bit_end_s = (baud_cnt_r == BIT_LAST_C);

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH_C; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[FIFO_AW-1:0]] <= in_byte;
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
        end
    end

    // Sticky overflow flag; a set on the same edge as a clear takes priority
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_r <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

    // Serialiser state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= IDLE_S;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shifter_r  <= 8'h00;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_n_s;
            baud_cnt_r <= baud_cnt_n_s;
            bit_idx_r  <= bit_idx_n_s;
            shifter_r  <= shifter_n_s;
            tx_r       <= tx_n_s;
        end
    end

    // Next-state logic; the line value is computed alongside so it stays registered
    always_comb begin
        state_n_s    = state_r;
        baud_cnt_n_s = baud_cnt_r;
        bit_idx_n_s  = bit_idx_r;
        shifter_n_s  = shifter_r;
        tx_n_s       = tx_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE_S: begin
                tx_n_s       = 1'b1;
                baud_cnt_n_s = 16'd0;
                if (level_s != '0) begin
                    pop_s       = 1'b1;
                    shifter_n_s = mem_r[rd_ptr_r[FIFO_AW-1:0]];
                    state_n_s   = START_S;
                    tx_n_s      = 1'b0;
                end else begin
                    state_n_s = IDLE_S;
                end
            end
            START_S: begin
                if (bit_end_s) begin
                    baud_cnt_n_s = 16'd0;
                    bit_idx_n_s  = 3'd0;
                    state_n_s    = DATA_S;
                    tx_n_s       = shifter_r[0];
                end else begin
                    baud_cnt_n_s = baud_cnt_r + 16'd1;
                end
            end
            DATA_S: begin
                if (bit_end_s) begin
                    baud_cnt_n_s = 16'd0;
                    shifter_n_s  = {1'b0, shifter_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_n_s = STOP_S;
                        tx_n_s    = 1'b1;
                    end else begin
                        bit_idx_n_s = bit_idx_r + 3'd1;
                        tx_n_s      = shifter_r[1];
                    end
                end else begin
                    baud_cnt_n_s = baud_cnt_r + 16'd1;
                end
            end
            STOP_S: begin
                if (bit_end_s) begin
                    baud_cnt_n_s = 16'd0;
                    // Back-to-back frames: reload straight into START without an idle cycle
                    if (level_s != '0) begin
                        pop_s       = 1'b1;
                        shifter_n_s = mem_r[rd_ptr_r[FIFO_AW-1:0]];
                        state_n_s   = START_S;
                        tx_n_s      = 1'b0;
                    end else begin
                        state_n_s = IDLE_S;
                        tx_n_s    = 1'b1;
                    end
                end else begin
                    baud_cnt_n_s = baud_cnt_r + 16'd1;
                end
            end
            default: begin
                state_n_s    = IDLE_S;
                baud_cnt_n_s = 16'd0;
                tx_n_s       = 1'b1;
            end
        endcase
    end

    assign uart_tx    = tx_r;
    assign tx_busy    = (state_r != IDLE_S);
    assign fifo_level = level_s;
    assign fifo_full  = full_s;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_out_byte_uart_tx.sv
// Self-checking bench: a frame-schedule model of the UART bridge checked every cycle,
// plus hand-computed frames, levels and flag checks; a second instance covers the minimum divider.
module tb_out_byte_uart_tx;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [7:0]    in_byte = 8'h00;
    logic          in_byte_en = 1'b0;
    logic          overflow_clr = 1'b0;
    logic          uart_tx, tx_busy, fifo_full, overflow;
    logic [AW:0]   fifo_level;

    logic [7:0]    in_byte2 = 8'h00;
    logic          in_byte_en2 = 1'b0;
    logic          overflow_clr2 = 1'b0;
    logic          uart_tx2, tx_busy2, fifo_full2, overflow2;
    logic [AW:0]   fifo_level2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    out_byte_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) u_dut (
        .clk(clk), .resetn(resetn), .in_byte(in_byte), .in_byte_en(in_byte_en),
        .overflow_clr(overflow_clr), .uart_tx(uart_tx), .tx_busy(tx_busy),
        .fifo_level(fifo_level), .fifo_full(fifo_full), .overflow(overflow));

    out_byte_uart_tx #(.CLKS_PER_BIT(2), .FIFO_AW(AW)) u_dut2 (
        .clk(clk), .resetn(resetn), .in_byte(in_byte2), .in_byte_en(in_byte_en2),
        .overflow_clr(overflow_clr2), .uart_tx(uart_tx2), .tx_busy(tx_busy2),
        .fifo_level(fifo_level2), .fifo_full(fifo_full2), .overflow(overflow2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting bytes plus the cycle offset within the current frame
    logic [7:0] m_q[$];
    logic [7:0] m_cur = 8'h00;
    bit         m_busy = 1'b0;
    int         m_t = 0;
    bit         m_ovf = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q.delete();
            m_busy = 1'b0;
            m_t    = 0;
            m_ovf  = 1'b0;
        end else begin
            int pre;
            pre = m_q.size();
            if (m_busy) begin
                m_t++;
                if (m_t == 10 * CPB) m_busy = 1'b0;
            end
            if (!m_busy && pre != 0) begin
                m_cur  = m_q.pop_front();
                m_busy = 1'b1;
                m_t    = 0;
            end
            if (in_byte_en && pre == (1 << AW)) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
            if (in_byte_en && pre != (1 << AW)) m_q.push_back(in_byte);
        end
    end

    function automatic logic model_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k >= 9) return 1'b1;
        return m_cur[k-1];
    endfunction

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_tx", {31'd0, uart_tx}, {31'd0, model_tx()});
        chk("model_busy", {31'd0, tx_busy}, {31'd0, m_busy});
        chk("model_level", {27'd0, fifo_level}, 32'(m_q.size()));
        chk("model_full", {31'd0, fifo_full}, {31'd0, (m_q.size() == (1 << AW))});
        chk("model_ovf", {31'd0, overflow}, {31'd0, m_ovf});
    end

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!tx_busy && fifo_level == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("wait_idle", {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  exp_a5;
        logic [19:0] exp_min;
        exp_a5  = 10'b1101001010;
        exp_min = 20'b10000000001111111110;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_busy", {31'd0, tx_busy}, 32'd0);
        chk("rst_level", {27'd0, fifo_level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        // Single 0xA5 frame
        @(posedge clk); #1 in_byte = 8'hA5; in_byte_en = 1'b1;
        @(posedge clk); #1 in_byte_en = 1'b0;
        @(negedge clk);
        chk("a5_level_after_push", {27'd0, fifo_level}, 32'd1);
        chk("a5_tx_before_start", {31'd0, uart_tx}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("a5_line", {31'd0, uart_tx}, {31'd0, exp_a5[i/4]});
            chk("a5_busy", {31'd0, tx_busy}, 32'd1);
            if (i == 0) chk("a5_level_popped", {27'd0, fifo_level}, 32'd0);
        end
        @(negedge clk);
        chk("a5_busy_end", {31'd0, tx_busy}, 32'd0);
        chk("a5_tx_end", {31'd0, uart_tx}, 32'd1);

        // Three back-to-back bytes
        @(posedge clk); #1 in_byte = 8'h48; in_byte_en = 1'b1;
        @(posedge clk); #1 in_byte = 8'h69;
        @(negedge clk); chk("hi_level0", {27'd0, fifo_level}, 32'd1);
        @(posedge clk); #1 in_byte = 8'h0A;
        @(negedge clk); chk("hi_level1", {27'd0, fifo_level}, 32'd1);
        @(posedge clk); #1 in_byte_en = 1'b0;
        @(negedge clk); chk("hi_level2", {27'd0, fifo_level}, 32'd2);
        repeat (38) @(negedge clk);
        chk("hi_level_frame1_end", {27'd0, fifo_level}, 32'd2);
        @(negedge clk);
        chk("hi_level_frame2", {27'd0, fifo_level}, 32'd1);
        chk("hi_no_gap", {31'd0, uart_tx}, 32'd0);
        wait_idle(200);

        // Overfill: 18 strobes, last one dropped
        for (int k = 0; k < 18; k++) begin
            @(posedge clk); #1 in_byte = 8'(k); in_byte_en = 1'b1;
            if (k == 17) begin
                @(negedge clk);
                chk("ovf_full_after_17", {31'd0, fifo_full}, 32'd1);
                chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
            end
        end
        @(posedge clk); #1 in_byte_en = 1'b0;
        @(negedge clk);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_level16", {27'd0, fifo_level}, 32'd16);

        // Overflow clear, then clear colliding with a dropped push
        @(posedge clk); #1 overflow_clr = 1'b1;
        @(posedge clk); #1 overflow_clr = 1'b0;
        @(negedge clk); chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        @(posedge clk); #1 overflow_clr = 1'b1; in_byte = 8'h99; in_byte_en = 1'b1;
        @(posedge clk); #1 overflow_clr = 1'b0; in_byte_en = 1'b0;
        @(negedge clk); chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        @(posedge clk); #1 overflow_clr = 1'b1;
        @(posedge clk); #1 overflow_clr = 1'b0;
        wait_idle(1000);

        // Asynchronous reset mid-frame with bytes queued
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1 in_byte = 8'h00; in_byte_en = 1'b1;
        end
        @(posedge clk); #1 in_byte_en = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("rst_mid_line_low", {31'd0, uart_tx}, 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_mid_level", {27'd0, fifo_level}, 32'd0);
        chk("rst_mid_busy", {31'd0, tx_busy}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;
        repeat (60) @(negedge clk);
        chk("rst_after_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_after_busy", {31'd0, tx_busy}, 32'd0);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_byte      = 8'($urandom);
            in_byte_en   = ($urandom_range(0, 99) < 35);
            overflow_clr = ($urandom_range(0, 63) == 0);
        end
        @(posedge clk); #1 in_byte_en = 1'b0; overflow_clr = 1'b0;
        wait_idle(1000);

        // Minimum divider: 0xFF then 0x00 on the second instance
        @(posedge clk); #1 in_byte2 = 8'hFF; in_byte_en2 = 1'b1;
        @(posedge clk); #1 in_byte2 = 8'h00;
        @(posedge clk); #1 in_byte_en2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("min_line", {31'd0, uart_tx2}, {31'd0, exp_min[i/2]});
            chk("min_busy", {31'd0, tx_busy2}, 32'd1);
        end
        @(negedge clk);
        chk("min_busy_end", {31'd0, tx_busy2}, 32'd0);
        chk("min_tx_end", {31'd0, uart_tx2}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
